demux_route_ctrl: RTL and testbench
===================================

# demux_route_ctrl

Upstream feeder for the 1-to-4 demultiplexer stage. It accepts single-bit data items tagged with a logical destination channel over a valid/ready handshake and buffers them in a small FIFO. It issues at most one item per cycle as registered `f`/`sel` drives, holding an item back while its destination channel reports busy. It also owns the logical-channel-to-`sel` encoding so downstream consumers index channels 0..3 as a, b, c, d.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `CW`, 5, width of `level`; must hold DEPTH (5 covers up to 16)
- `clk`  in  1  single clock, all state on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream item present
- `in_dest`  in  2  logical channel: 0=a, 1=b, 2=c, 3=d
- `in_bit`  in  1  data bit to route
- `in_ready`  out  1  FIFO can accept this cycle
- `flush`  in  1  synchronous: discard all buffered items
- `dest_busy`  in  4  bit i high means channel i must not receive an issue
- `f`  out  1  registered data to the demux input
- `sel`  out  2  registered demux select
- `out_valid`  out  1  registered; `f`/`sel` carry an issued item this cycle
- `level`  out  CW  current FIFO occupancy, 0..DEPTH

## Operation
- Channel encoding is fixed: `sel = {dest[0], dest[1]}`.
  - Channel 0 → 2'b00 (a), 1 → 2'b10 (b), 2 → 2'b01 (c), 3 → 2'b11 (d).
- Push:
  - `in_ready = (level != DEPTH) && !flush`, combinational from registered state only.
  - The item is written when `in_valid && in_ready` at a clock edge.
- Pop/issue at each edge:
  - Condition: FIFO non-empty, `!flush`, and `!dest_busy[head.dest]`.
  - The head is popped. Registers load `f <= head.bit`, `sel <= enc(head.dest)`, `out_valid <= 1`.
- No issue at an edge:
  - `out_valid <= 0` and `f <= 0`.
  - `sel` holds its previous value, so there are no spurious select toggles.
- Ordering:
  - Strict in-order. A blocked head stalls all later items, including items for free channels.
- Simultaneous push and pop in the same cycle:
  - Both occur and `level` is unchanged.
  - Full FIFO: no push that cycle, even if a pop happens (no bypass).
  - Empty FIFO: no push-to-issue bypass. An item needs one edge in the FIFO before it can issue.
- Flush:
  - Discards all entries: `level <= 0` and pointers reset.
  - Forces `out_valid <= 0` and `f <= 0`; `sel` holds.
  - A push presented in the same cycle is not accepted (`in_ready` is 0).
- Pointers wrap modulo DEPTH. `level` is a separate counter.
- Reset values (asynchronous, immediate):
  - `f=0`, `sel=2'b00`, `out_valid=0`, `level=0`, pointers 0.
  - `in_ready=1` while `rstn` is high after reset.
  - Reset mid-operation discards all items.

## Timing
- Latency: item accepted at edge k appears on `f`/`sel`/`out_valid` after edge k+1 at the earliest.
- Throughput: 1 item/cycle sustained when the head destination is not busy.
- `dest_busy` is sampled at the issue edge. Raising it in cycle k blocks the issue at edge k.
- `level` updates at the same edge as push/pop.
- `out_valid` is a one-cycle strobe per item.
  - Back-to-back items give continuous `out_valid=1` with `sel` changing per item.

## Test plan
- **Reset, then a single item:**
  - Push dest=1, bit=1 at edge 1.
  - Required: after edge 2, `out_valid=1`, `f=1`, `sel=2'b10`. After edge 3, `out_valid=0`, `f=0`, `sel=2'b10`.
- **Channel map:**
  - Push dest 0,1,2,3 back-to-back, all bit=1.
  - Required: `sel` sequence 00,10,01,11 on consecutive cycles with `out_valid=1` throughout.
- **Full and backpressure (DEPTH=4):**
  - With `dest_busy=4'b1111`, push 5 items.
  - Required: `level=4`, `in_ready=0`, 5th item not accepted.
  - Release busy. Required: 4 issues in order, then `level=0` and `in_ready=1`.
- **Head-of-line blocking:**
  - Queue dest 2 then dest 0 with `dest_busy=4'b0100` for 3 cycles.
  - Required: no issue while busy; dest 2 issues first on release, then dest 0.
- **Simultaneous push and pop:**
  - At `level=2`, push and issue in the same cycle.
  - Required: `level` stays 2 and ordering is preserved across pointer wrap over 10 items.
- **Flush and async reset mid-stream:**
  - Assert `flush` at `level=3`. Required: next cycle `level=0`, `out_valid=0`, `in_ready=1`.
  - Drop `rstn` between edges. Required: outputs go to reset values immediately.

Source files
------------

// File: rtl/demux_route_ctrl.sv
// demux_route_ctrl: buffers destination-tagged single-bit items in a small
// in-order FIFO and issues at most one per cycle as registered f/sel drives
// for the 1-to-4 demux, stalling while the head's channel reports busy.
module demux_route_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [1:0]    in_dest,
  input  logic          in_bit,
  output logic          in_ready,
  input  logic          flush,
  input  logic [3:0]    dest_busy,
  output logic          f,
  output logic [1:0]    sel,
  output logic          out_valid,
  output logic [CW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  // Each entry packs {dest[1:0], bit}.
  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_level;
  logic          r_f;
  logic [1:0]    r_sel;
  logic          r_out_valid;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [2:0]    w_head;
  logic [1:0]    w_head_dest;
  logic          w_head_bit;
  logic [1:0]    w_head_sel;

  assign w_empty     = (r_level == '0);
  assign in_ready    = (r_level != CW'(DEPTH)) && !flush;
  assign w_push      = in_valid && in_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_dest = w_head[2:1];
  assign w_head_bit  = w_head[0];
  // Logical channel 0..3 (a..d) maps to sel with the dest bits swapped.
  assign w_head_sel  = {w_head_dest[0], w_head_dest[1]};
  // Pop decisions use only pre-edge occupancy, so a push into an empty FIFO
  // can never issue in the same cycle.
  assign w_pop       = !w_empty && !flush && !dest_busy[w_head_dest];

  // Storage write on accepted push; contents need no reset since level gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_dest, in_bit};
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + CW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - CW'(1);
      end
    end
  end

  // Registered issue drives; sel holds when nothing issues to avoid select glitches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_f         <= 1'b0;
      r_sel       <= 2'b00;
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_f         <= w_head_bit;
      r_sel       <= w_head_sel;
      r_out_valid <= 1'b1;
    end else begin
      r_f         <= 1'b0;
      r_out_valid <= 1'b0;
    end
  end

  assign f         = r_f;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign level     = r_level;

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Scoreboard bench for demux_route_ctrl: a queue-based reference model
// predicts issues at each edge; a monitor compares on the falling edge.
module tb_demux_route_ctrl;

  localparam int DEPTH = 4;
  localparam int CW    = 5;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic [1:0]    in_dest;
  logic          in_bit;
  logic          in_ready;
  logic          flush;
  logic [3:0]    dest_busy;
  logic          f;
  logic [1:0]    sel;
  logic          out_valid;
  logic [CW-1:0] level;

  demux_route_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .flush     (flush),
    .dest_busy (dest_busy),
    .f         (f),
    .sel       (sel),
    .out_valid (out_valid),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dest;
    logic       b;
  } item_t;

  item_t      mq[$];       // model FIFO contents
  logic [2:0] exp_q[$];    // expected {f, sel} per issued item
  logic       m_issued;
  logic [1:0] m_sel;
  logic [1:0] ENC [4];

  int n_tests;
  int n_fail;

  initial begin
    ENC[0] = 2'b00; ENC[1] = 2'b10; ENC[2] = 2'b01; ENC[3] = 2'b11;
    n_tests = 0;
    n_fail  = 0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-order queue, issue decided from pre-edge state.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      exp_q.delete();
      m_issued = 1'b0;
      m_sel    = 2'b00;
    end else begin
      automatic bit pop = (mq.size() > 0) && !flush && !dest_busy[mq[0].dest];
      automatic bit acc = in_valid && (mq.size() < DEPTH) && !flush;
      item_t it;
      if (flush) mq.delete();
      m_issued = pop;
      if (pop) begin
        exp_q.push_back({mq[0].b, ENC[mq[0].dest]});
        m_sel = ENC[mq[0].dest];
        void'(mq.pop_front());
      end
      if (acc) begin
        it.dest = in_dest;
        it.b    = in_bit;
        mq.push_back(it);
      end
    end
  end

  // Monitor: compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    logic [2:0] e;
    check("out_valid", int'(out_valid), int'(m_issued));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("f", int'(f), int'(e[2]));
        check("sel_issue", int'(sel), int'(e[1:0]));
      end
    end else begin
      check("f_idle", int'(f), 0);
    end
    check("sel_hold", int'(sel), int'(m_sel));
    check("level", int'(level), mq.size());
    check("in_ready", int'(in_ready), int'((mq.size() != DEPTH) && !flush));
  end

  task automatic step(input logic v, input logic [1:0] d, input logic b,
                      input logic [3:0] bz, input logic fl);
    in_valid  = v;
    in_dest   = d;
    in_bit    = b;
    dest_busy = bz;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] bz);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, bz, 1'b0);
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_dest   = 2'd0;
    in_bit    = 1'b0;
    dest_busy = 4'b0000;
    flush     = 1'b0;
    #12;
    rstn = 1'b1;
    #1;
    check("reset_level", int'(level), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_sel", int'(sel), 0);
    check("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Single item dest=1 bit=1
    step(1'b1, 2'd1, 1'b1, 4'b0000, 1'b0);
    idle(3, 4'b0000);

    // Channel map, back-to-back
    for (int d = 0; d < 4; d++) step(1'b1, 2'(d), 1'b1, 4'b0000, 1'b0);
    idle(3, 4'b0000);

    // Full and backpressure
    for (int i = 0; i < 5; i++) step(1'b1, 2'(i % 4), 1'(i % 2), 4'b1111, 1'b0);
    check("full_level", int'(level), DEPTH);
    check("full_in_ready", int'(in_ready), 0);
    idle(6, 4'b0000);
    check("drained_level", int'(level), 0);

    // Head-of-line blocking
    step(1'b1, 2'd2, 1'b1, 4'b0100, 1'b0);
    step(1'b1, 2'd0, 1'b0, 4'b0100, 1'b0);
    idle(3, 4'b0100);
    idle(4, 4'b0000);

    // Simultaneous push/pop at level 2 across pointer wrap
    step(1'b1, 2'd3, 1'b1, 4'b1111, 1'b0);
    step(1'b1, 2'd1, 1'b0, 4'b1111, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'($urandom_range(3)), 1'($urandom_range(1)), 4'b0000, 1'b0);
      check("steady_level", int'(level), 2);
    end
    idle(4, 4'b0000);

    // Flush at level 3
    for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 1'b1, 4'b1111, 1'b0);
    step(1'b1, 2'd0, 1'b1, 4'b0000, 1'b1);
    check("flush_level", int'(level), 0);
    check("flush_out_valid", int'(out_valid), 0);
    idle(2, 4'b0000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] bz;
      for (int k = 0; k < 4; k++) bz[k] = ($urandom_range(3) == 0);
      step(1'($urandom_range(3) != 0), 2'($urandom_range(3)), 1'($urandom_range(1)),
           bz, 1'($urandom_range(40) == 0));
    end
    idle(DEPTH + 2, 4'b0000);

    // Async reset mid-stream
    step(1'b1, 2'd3, 1'b1, 4'b0000, 1'b0);
    step(1'b1, 2'd1, 1'b1, 4'b0000, 1'b0);
    step(1'b1, 2'd0, 1'b1, 4'b1111, 1'b0);
    step(1'b1, 2'd2, 1'b1, 4'b1111, 1'b0);
    #1;
    rstn = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_f", int'(f), 0);
    check("arst_sel", int'(sel), 0);
    check("arst_level", int'(level), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 2'(i % 4), 1'b1, 4'b0000, 1'b0);
    idle(DEPTH + 2, 4'b0000);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
